// File: rtl/minirisc_pkg.sv
// Shared miniRISC execute-unit types: datapath widths, the registered result beat
// and the result-stage occupancy states.
package minirisc_pkg;

    localparam int WIDTH = 32;
    localparam int RA_W  = 5;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [RA_W-1:0]  rd;
        logic             wr_en;
        logic             set_flags;
        logic             zero;
        logic             sign;
        logic             carry;
    } alu_beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_result_stage_flag_gen.sv
// Combinational zero/sign/carry generator for an ALU result; also used by the
// branch unit.
module flag_gen
    import minirisc_pkg::*;
(
    input  logic [WIDTH-1:0] i_result,
    input  logic             i_carry,
    output logic             o_zero,
    output logic             o_sign,
    output logic             o_carry
);

    assign o_zero  = (i_result == '0);
    assign o_sign  = i_result[WIDTH-1];
    assign o_carry = i_carry;

endmodule

// File: rtl/alu_result_stage.sv
// Registered execute-unit output stage: 2-entry skid buffer toward writeback with
// a registered in_ready, per-beat flags and persistent branch flags.
module alu_result_stage
    import minirisc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    input  logic [RA_W-1:0]  in_rd,
    input  logic             in_wr_en,
    input  logic             in_set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RA_W-1:0]  out_rd,
    output logic             out_wr_en,
    output logic             out_zero,
    output logic             out_sign,
    output logic             out_carry,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c
);

    state_t    r_state;
    state_t    w_next;
    alu_beat_t r_main;
    alu_beat_t r_skid;
    alu_beat_t w_beat;
    logic      r_in_ready;
    logic      r_flag_z;
    logic      r_flag_n;
    logic      r_flag_c;
    logic      w_zero;
    logic      w_sign;
    logic      w_carry;
    logic      w_acc;
    logic      w_dlv;

    flag_gen u_flag_gen (
        .i_result (in_result),
        .i_carry  (in_carry),
        .o_zero   (w_zero),
        .o_sign   (w_sign),
        .o_carry  (w_carry)
    );

    always_comb begin
        w_beat           = '0;
        w_beat.result    = in_result;
        w_beat.rd        = in_rd;
        w_beat.wr_en     = in_wr_en;
        w_beat.set_flags = in_set_flags;
        w_beat.zero      = w_zero;
        w_beat.sign      = w_sign;
        w_beat.carry     = w_carry;
    end

    assign w_acc = in_valid && r_in_ready;
    assign w_dlv = (r_state != EMPTY) && out_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            EMPTY: if (w_acc) w_next = ONE;
            ONE: begin
                if (w_acc && !w_dlv)      w_next = TWO;
                else if (!w_acc && w_dlv) w_next = EMPTY;
            end
            TWO:   if (w_dlv) w_next = ONE;
            default: w_next = EMPTY;
        endcase
    end

    // in_ready is precomputed from the next state so upstream sees a flop, not a comb path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
            r_flag_z   <= 1'b0;
            r_flag_n   <= 1'b0;
            r_flag_c   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != TWO);
            if (w_dlv && r_main.set_flags) begin
                r_flag_z <= r_main.zero;
                r_flag_n <= r_main.sign;
                r_flag_c <= r_main.carry;
            end
            case (r_state)
                EMPTY: if (w_acc) r_main <= w_beat;
                ONE: begin
                    if (w_acc && w_dlv)       r_main <= w_beat;
                    else if (w_acc && !w_dlv) r_skid <= w_beat;
                end
                TWO:   if (w_dlv) r_main <= r_skid;
                default: ;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = (r_state != EMPTY);
    assign out_result = r_main.result;
    assign out_rd     = r_main.rd;
    assign out_wr_en  = r_main.wr_en;
    assign out_zero   = r_main.zero;
    assign out_sign   = r_main.sign;
    assign out_carry  = r_main.carry;
    assign flag_z     = r_flag_z;
    assign flag_n     = r_flag_n;
    assign flag_c     = r_flag_c;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus random traffic, checked
// against an in-order FIFO model of the stage.
module tb_alu_result_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_carry;
    logic [4:0]  in_rd;
    logic        in_wr_en;
    logic        in_set_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wr_en;
    logic        out_zero;
    logic        out_sign;
    logic        out_carry;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;

    alu_result_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_carry     (in_carry),
        .in_rd        (in_rd),
        .in_wr_en     (in_wr_en),
        .in_set_flags (in_set_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_wr_en    (out_wr_en),
        .out_zero     (out_zero),
        .out_sign     (out_sign),
        .out_carry    (out_carry),
        .flag_z       (flag_z),
        .flag_n       (flag_n),
        .flag_c       (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic [4:0]  rd;
        logic        wr;
        logic        sf;
    } mbeat_t;

    mbeat_t m_q[$];
    logic   m_ready;
    logic   m_z, m_n, m_c;
    logic   m_after_rst;
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the model's view of the stage.
    task automatic check_all();
        mbeat_t h;
        chk("out_valid", {31'd0, out_valid}, {31'd0, (m_q.size() != 0)});
        chk("in_ready",  {31'd0, in_ready},  {31'd0, m_ready});
        chk("flag_z",    {31'd0, flag_z},    {31'd0, m_z});
        chk("flag_n",    {31'd0, flag_n},    {31'd0, m_n});
        chk("flag_c",    {31'd0, flag_c},    {31'd0, m_c});
        if (m_q.size() != 0) begin
            h = m_q[0];
            chk("out_result", out_result, h.res);
            chk("out_rd",     {27'd0, out_rd}, {27'd0, h.rd});
            chk("out_wr_en",  {31'd0, out_wr_en}, {31'd0, h.wr});
            chk("out_zero",   {31'd0, out_zero},  {31'd0, (h.res == 32'd0)});
            chk("out_sign",   {31'd0, out_sign},  {31'd0, (h.res >= 32'h8000_0000)});
            chk("out_carry",  {31'd0, out_carry}, {31'd0, h.c});
        end else if (m_after_rst) begin
            chk("rst_payload", out_result, 32'd0);
            chk("rst_meta", {24'd0, out_rd, out_wr_en, out_zero, out_sign}, 32'd0);
            chk("rst_carry", {31'd0, out_carry}, 32'd0);
        end
    endtask

    task automatic step(input logic iv, input logic [31:0] res, input logic c,
                        input logic [4:0] rd, input logic wr, input logic sf,
                        input logic ordy);
        logic   acc, dlv;
        mbeat_t b, h;
        in_valid = iv; in_result = res; in_carry = c; in_rd = rd;
        in_wr_en = wr; in_set_flags = sf; out_ready = ordy;
        acc = iv && m_ready;
        dlv = (m_q.size() != 0) && ordy;
        b.res = res; b.c = c; b.rd = rd; b.wr = wr; b.sf = sf;
        @(posedge clk);
        if (dlv) begin
            h = m_q.pop_front();
            if (h.sf) begin
                m_z = (h.res == 32'd0);
                m_n = (h.res >= 32'h8000_0000);
                m_c = h.c;
            end
        end
        if (acc) begin
            m_q.push_back(b);
            m_after_rst = 1'b0;
        end
        m_ready = (m_q.size() < 2);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input logic iv);
        rst = 1'b1; in_valid = iv; in_result = $urandom(); out_ready = 1'b1;
        @(posedge clk);
        m_q.delete();
        m_ready = 1'b1; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_after_rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_result = 32'd0; in_carry = 1'b0;
        in_rd = 5'd0; in_wr_en = 1'b0; in_set_flags = 1'b0; out_ready = 1'b0;
        m_ready = 1'b1; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_after_rst = 1'b1;

        do_reset(1'b1);

        // streaming with out_ready high
        step(1'b1, 32'h0000_0000, 1'b0, 5'd1, 1'b1, 1'b1, 1'b1);
        chk("stream0_znc", {29'd0, out_zero, out_sign, out_carry}, 32'b100);
        step(1'b1, 32'h8000_0001, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1);
        chk("stream1_znc", {29'd0, out_zero, out_sign, out_carry}, 32'b011);
        step(1'b1, 32'h7FFF_FFFF, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1);
        chk("stream2_znc", {29'd0, out_zero, out_sign, out_carry}, 32'b000);
        idle(1);
        chk("stream_flags", {29'd0, flag_z, flag_n, flag_c}, 32'b000);

        // backpressure: two beats accepted, upstream keeps retrying the rest
        step(1'b1, 32'd1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'd2, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
        step(1'b1, 32'd3, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'd3, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        chk("bp_head_held", out_result, 32'd1);
        step(1'b1, 32'd3, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
        chk("bp_rel_head", out_result, 32'd2);
        step(1'b1, 32'd3, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'd4, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
        chk("bp_last", out_result, 32'd4);
        idle(1);

        // accept and deliver in the same cycle while holding one beat
        step(1'b1, 32'h10, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h20, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
        chk("sim_head", out_result, 32'h20);
        chk("sim_ready", {31'd0, in_ready}, 32'd1);
        idle(1);

        // set_flags gating
        step(1'b1, 32'h0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1);
        chk("sf_hold", {29'd0, flag_z, flag_n, flag_c}, 32'b000);
        idle(1);
        chk("sf_load", {29'd0, flag_z, flag_n, flag_c}, 32'b011);

        // reset while full
        step(1'b1, 32'h111, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h222, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        do_reset(1'b1);
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        step(1'b1, 32'hABCD, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1);
        chk("mrst_beat", out_result, 32'hABCD);
        idle(2);

        // rd / wr_en passthrough
        step(1'b1, 32'd5, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0);
        chk("pt_rd", {27'd0, out_rd}, 32'd31);
        chk("pt_wr", {31'd0, out_wr_en}, 32'd0);
        chk("pt_res", out_result, 32'd5);
        idle(1);

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                step(1'($urandom_range(0, 1)),
                     ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom(),
                     1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) != 0));
            end
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage of the miniRISC execute unit. It consumes the 32-bit result selected from the ALU function units (adder, logic, shifter, DIFF) together with its destination register tag. It computes zero, sign and carry flags and presents the beat to writeback over a valid/ready handshake. A 2-entry skid buffer keeps `in_ready` fully registered while sustaining one beat per cycle; a persistent flag register feeds branch resolution.

## Interface
- `WIDTH`, 32, datapath width in bits.
- `RA_W`, 5, register address width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  stage can accept a beat; registered.
- `in_result`  in  WIDTH  selected ALU result.
- `in_carry`  in  1  carry/borrow from the adder; ignored for non-arithmetic ops.
- `in_rd`  in  RA_W  destination register.
- `in_wr_en`  in  1  result is to be written to `in_rd`.
- `in_set_flags`  in  1  the beat updates the persistent flags.
- `out_valid`  out  1  head beat valid.
- `out_ready`  in  1  writeback accepts the head beat.
- `out_result`  out  WIDTH  head result.
- `out_rd`  out  RA_W  head destination.
- `out_wr_en`  out  1  head write enable.
- `out_zero`, `out_sign`, `out_carry`  out  1 each  flags of the head beat.
- `flag_z`, `flag_n`, `flag_c`  out  1 each  persistent flags, used for branch resolution.

## Operation
- Accept when `in_valid && in_ready`. Deliver when `out_valid && out_ready`.
- Flags are computed at acceptance and stored with the beat:
  - zero = (`in_result` == 0)
  - sign = `in_result[WIDTH-1]`
  - carry = `in_carry`
- The stored payload per entry is result, rd, wr_en, set_flags, zero, sign and carry.
- Entries are `main` (drives all out_* signals) and `skid`.
- States and transitions:
  - EMPTY: on accept -> ONE (beat loads into main).
  - ONE:
    - accept without deliver -> TWO (beat loads into skid).
    - deliver without accept -> EMPTY.
    - accept and deliver together -> ONE (main reloads with the new beat).
  - TWO: no accept is possible. On deliver -> ONE (skid moves to main).
- `in_ready` = next_state != TWO, registered. It is therefore high in EMPTY and ONE, and low in TWO.
- `out_valid` = (state != EMPTY).
- Beats always leave in acceptance order. No beat is ever dropped or duplicated.
- Persistent flags load {zero, sign, carry} of the head beat on a deliver whose set_flags = 1. Otherwise they hold.
- Payload outputs are don't-care when `out_valid` = 0, but are held stable while `out_valid && !out_ready`.

## Timing
- Latency is 1 cycle: a beat accepted at edge k is on out_* at edge k, visible the cycle after.
- Throughput is 1 beat/cycle whenever `out_ready` is held high.
- Persistent flags change on the edge of the delivering handshake and are visible the following cycle.
- Reset values, with `rst` sampled high at an edge:
  - state = EMPTY, `in_ready` = 1, `out_valid` = 0.
  - all payload outputs = 0.
  - `flag_z`/`flag_n`/`flag_c` = 0.
- Reset mid-operation discards both entries. No handshake occurs on the reset edge.
- Backpressure: `out_ready` low for N cycles while `in_valid` is high. The stage fills to TWO, `in_ready` drops the cycle after the second accept, and nothing is lost.

## Structure
- Shared package `minirisc_pkg`:
  - `WIDTH` and `RA_W` constants.
  - `alu_beat_t` struct (result, rd, wr_en, set_flags, zero, sign, carry).
  - state enum {EMPTY, ONE, TWO}.
- One natural sub-module, `flag_gen`: a combinational {zero, sign, carry} generator, reused by the branch unit.
- Everything else lives in one always_ff block plus next-state logic.

## Test plan
- Streaming, `out_ready` = 1:
  - stimulus: results 0x00000000, 0x80000001, 0x7FFFFFFF on consecutive cycles, set_flags = 1, carry = 0,1,0.
  - response: identical order 1 cycle later, one per cycle.
  - out flags (z,n,c) = (1,0,0), (0,1,1), (0,0,0).
  - final persistent flags = (0,0,0).
- Backpressure:
  - stimulus: `out_ready` = 0 for 4 cycles with `in_valid` held high, values 1,2,3,4.
  - response: exactly 2 beats accepted, `in_ready` = 0 after the second accept.
  - release: delivers 1,2,3,4 in order with no loss.
- Simultaneous accept and deliver in ONE:
  - stimulus: head 0x10, new beat 0x20 with `out_ready` = 1.
  - response: stays ONE, head becomes 0x20 next cycle, `in_ready` stays 1.
- set_flags gating:
  - stimulus: deliver result 0 with set_flags = 0, then 0xFFFFFFFF with set_flags = 1.
  - response: persistent flags stay (0,0,0) after the first beat, then become (0,1,c).
- Reset mid-operation:
  - stimulus: assert `rst` one cycle while in TWO.
  - response: next cycle `out_valid` = 0, `in_ready` = 1, all payload outputs and flags = 0.
  - a following beat 0xABCD emerges alone.
- wr_en/rd passthrough:
  - stimulus: rd = 31, wr_en = 0, result 5.
  - response: `out_rd` = 31, `out_wr_en` = 0, `out_result` = 5.
